// File: rtl/syscall_console.sv
// Syscall service unit: renders print_int / print_string / print_char
// as an ASCII stream on a valid/ready port, and latches exit.
module syscall_console #(
    parameter int MAX_STR = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_valid,
    output logic        sys_ready,
    input  logic [31:0] sys_code,
    input  logic [31:0] sys_arg,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [7:0]  out_char,
    input  logic        out_ready,
    output logic        halted
);

    localparam int CW = $clog2(MAX_STR + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHAR,
        SIGN,
        CALC,
        EMIT,
        STR_FETCH,
        STR_EMIT,
        HALT
    } state_t;

    state_t state;
    state_t stateNext;

    logic [7:0]    charReg;
    logic [31:0]   rem;
    logic [3:0]    k;
    logic [3:0]    digit;
    logic          started;
    logic [31:0]   ptr;
    logic [CW-1:0] count;
    logic [7:0]    strByte;

    logic          accept;
    logic          xfer;
    logic [31:0]   pow;
    logic          geq;
    logic          suppress;
    logic [7:0]    fetchByte;
    logic          fetchDone;

    function automatic logic [31:0] pow10(input logic [3:0] e);
        unique case (e)
            4'd9:    pow10 = 32'd1000000000;
            4'd8:    pow10 = 32'd100000000;
            4'd7:    pow10 = 32'd10000000;
            4'd6:    pow10 = 32'd1000000;
            4'd5:    pow10 = 32'd100000;
            4'd4:    pow10 = 32'd10000;
            4'd3:    pow10 = 32'd1000;
            4'd2:    pow10 = 32'd100;
            4'd1:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

    assign accept   = sys_valid && sys_ready;
    assign xfer     = out_valid && out_ready;
    assign pow      = pow10(k);
    assign geq      = rem >= pow;
    // Leading zeros are skipped, but the units digit always prints.
    assign suppress = (digit == 4'd0) && !started && (k != 4'd0);
    assign mem_addr = ptr[31:2];

    always_comb begin
        unique case (ptr[1:0])
            2'd0:    fetchByte = mem_rdata[7:0];
            2'd1:    fetchByte = mem_rdata[15:8];
            2'd2:    fetchByte = mem_rdata[23:16];
            default: fetchByte = mem_rdata[31:24];
        endcase
    end

    assign fetchDone = (fetchByte == 8'h00) || (count == CW'(MAX_STR));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        sys_code == 32'd11: stateNext = CHAR;
                        sys_code == 32'd1:
                            stateNext = sys_arg[31] ? SIGN : CALC;
                        sys_code == 32'd4:  stateNext = STR_FETCH;
                        sys_code == 32'd10: stateNext = HALT;
                        default:            stateNext = IDLE;
                    endcase
                end
            end
            CHAR:      if (xfer) stateNext = IDLE;
            SIGN:      if (xfer) stateNext = CALC;
            CALC:      if (!geq && !suppress) stateNext = EMIT;
            EMIT:      if (xfer) stateNext = (k == 4'd0) ? IDLE : CALC;
            STR_FETCH: stateNext = fetchDone ? IDLE : STR_EMIT;
            STR_EMIT:  if (xfer) stateNext = STR_FETCH;
            default:   stateNext = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            charReg <= '0;
            rem     <= '0;
            k       <= '0;
            digit   <= '0;
            started <= 1'b0;
            ptr     <= '0;
            count   <= '0;
            strByte <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        charReg <= sys_arg[7:0];
                        // -2^31 negates to itself, read as 2147483648.
                        rem     <= sys_arg[31] ? -sys_arg : sys_arg;
                        k       <= 4'd9;
                        digit   <= '0;
                        started <= 1'b0;
                        ptr     <= sys_arg;
                        count   <= '0;
                    end
                end
                CALC: begin
                    if (geq) begin
                        rem   <= rem - pow;
                        digit <= digit + 4'd1;
                    end else if (suppress) begin
                        k <= k - 4'd1;
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        digit   <= '0;
                        started <= 1'b1;
                        if (k != 4'd0) k <= k - 4'd1;
                    end
                end
                STR_FETCH: begin
                    if (!fetchDone) strByte <= fetchByte;
                end
                STR_EMIT: begin
                    if (xfer) begin
                        ptr   <= ptr + 32'd1;
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sys_ready = (state == IDLE);
        halted    = (state == HALT);
        out_valid = 1'b0;
        out_char  = 8'h00;
        unique case (state)
            CHAR: begin
                out_valid = 1'b1;
                out_char  = charReg;
            end
            SIGN: begin
                out_valid = 1'b1;
                out_char  = 8'h2D;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_char  = 8'h30 + {4'd0, digit};
            end
            STR_EMIT: begin
                out_valid = 1'b1;
                out_char  = strByte;
            end
            default: ;
        endcase
    end

endmodule
